// File: rtl/kbd_display_ports_pkg.sv
// Shared constants for the keyboard/display I/O port pair: register offsets,
// status bit positions, I/O base addresses and the display-side state type.
package kbd_display_ports_pkg;

   localparam logic STATUS = 1'b0;
   localparam logic BUFFER = 1'b1;

   localparam int FI_BIT  = 0;
   localparam int OVR_BIT = 1;
   localparam int FO_BIT  = 0;

   localparam logic [15:0] KBD_BASE = 16'h0000;
   localparam logic [15:0] DSP_BASE = 16'h0002;

   // EMPTY means the buffer may be written (FO=1); FULL means a character
   // is waiting for the display device (disp_valid=1).
   typedef enum logic {
      DSP_EMPTY = 1'b0,
      DSP_FULL  = 1'b1
   } dsp_state_e;

endpackage

// File: rtl/kbd_display_ports_if.sv
// Processor-side I/O bus control: port selects, register select and strobes.
interface kbd_display_ports_if;

   logic s_kbd_;
   logic s_dsp_;
   logic a0;
   logic ior_;
   logic iow_;

   modport master (output s_kbd_, s_dsp_, a0, ior_, iow_);
   modport slave  (input  s_kbd_, s_dsp_, a0, ior_, iow_);

endinterface

// File: rtl/kbd_display_ports_dsp_tx.sv
// Display transmit port: TBR capture from the bus and valid/ack handoff.
module dsp_tx_port
   import kbd_display_ports_pkg::*;
(
   input  logic       clock,
   input  logic       reset_,
   input  logic       sel_,
   input  logic       a0,
   input  logic       iow_,
   input  logic [7:0] wr_data,
   input  logic       disp_ack,
   output logic [7:0] tsr,
   output logic [7:0] tbr,
   output logic       disp_valid
);

   dsp_state_e state_q;
   dsp_state_e state_d;
   logic       wr_act;
   logic       wr_act_p1;
   logic       fo;

   assign wr_act = !sel_ && (a0 == BUFFER) && !iow_;
   assign fo     = (state_q == DSP_EMPTY);

   // TBR follows the bus for the whole strobe so the value present at the
   // trailing edge is the one handed to the display.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state_q   <= DSP_EMPTY;
         wr_act_p1 <= 1'b0;
         tbr       <= 8'h00;
      end else begin
         state_q   <= state_d;
         wr_act_p1 <= wr_act;
         if (wr_act && fo) begin
            tbr <= wr_data;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DSP_EMPTY: if (wr_act_p1 && !wr_act) state_d = DSP_FULL;
         DSP_FULL:  if (disp_ack)             state_d = DSP_EMPTY;
         default:                             state_d = DSP_EMPTY;
      endcase
   end

   always_comb begin
      tsr         = 8'h00;
      tsr[FO_BIT] = fo;
   end

   assign disp_valid = (state_q == DSP_FULL);

endmodule

// File: rtl/kbd_display_ports_kbd_rx.sv
// Keyboard receive port: latches key codes into RBR and tracks FI/OVR in RSR.
module kbd_rx_port
   import kbd_display_ports_pkg::*;
(
   input  logic       clock,
   input  logic       reset_,
   input  logic       sel_,
   input  logic       a0,
   input  logic       ior_,
   input  logic [7:0] key_code,
   input  logic       key_valid,
   output logic [7:0] rsr,
   output logic [7:0] rbr
);

   logic fi;
   logic ovr;
   logic rd_act;
   logic rd_act_p1;
   logic rd_end;

   assign rd_act = !sel_ && (a0 == BUFFER) && !ior_;
   assign rd_end = rd_act_p1 && !rd_act;

   // A key arriving on the same edge as the end of an RBR read wins: the
   // read consumed the old byte, so the new one is fresh and not an overrun.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         fi        <= 1'b0;
         ovr       <= 1'b0;
         rbr       <= 8'h00;
         rd_act_p1 <= 1'b0;
      end else begin
         rd_act_p1 <= rd_act;
         if (key_valid) begin
            rbr <= key_code;
            fi  <= 1'b1;
            ovr <= rd_end ? 1'b0 : (ovr | fi);
         end else if (rd_end) begin
            fi  <= 1'b0;
            ovr <= 1'b0;
         end
      end
   end

   always_comb begin
      rsr          = 8'h00;
      rsr[FI_BIT]  = fi;
      rsr[OVR_BIT] = ovr;
   end

endmodule

// File: rtl/kbd_display_ports.sv
// Keyboard + display I/O port pair; the top only steers the shared
// tri-state data bus between the two ports' registers.
module kbd_display_ports
   import kbd_display_ports_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset_,
   kbd_display_ports_if.slave        bus,
   inout  wire  [7:0]                d7_d0,
   input  logic [7:0]                key_code,
   input  logic                      key_valid,
   output logic [7:0]                disp_char,
   output logic                      disp_valid,
   input  logic                      disp_ack
);

   logic [7:0] rsr;
   logic [7:0] rbr;
   logic [7:0] tsr;
   logic [7:0] tbr;
   logic       kbd_rd;
   logic       dsp_rd;
   logic [7:0] rd_data;

   kbd_rx_port u_kbd_rx (
      .clock     (clock),
      .reset_    (reset_),
      .sel_      (bus.s_kbd_),
      .a0        (bus.a0),
      .ior_      (bus.ior_),
      .key_code  (key_code),
      .key_valid (key_valid),
      .rsr       (rsr),
      .rbr       (rbr)
   );

   dsp_tx_port u_dsp_tx (
      .clock      (clock),
      .reset_     (reset_),
      .sel_       (bus.s_dsp_),
      .a0         (bus.a0),
      .iow_       (bus.iow_),
      .wr_data    (d7_d0),
      .disp_ack   (disp_ack),
      .tsr        (tsr),
      .tbr        (tbr),
      .disp_valid (disp_valid)
   );

   // Both selects low is a decode fault upstream; stay off the bus then.
   assign kbd_rd = !bus.ior_ && !bus.s_kbd_ &&  bus.s_dsp_;
   assign dsp_rd = !bus.ior_ && !bus.s_dsp_ &&  bus.s_kbd_;

   always_comb begin
      rd_data = 8'h00;
      if (kbd_rd) rd_data = (bus.a0 == BUFFER) ? rbr : rsr;
      else        rd_data = (bus.a0 == BUFFER) ? tbr : tsr;
   end

   assign d7_d0     = (kbd_rd || dsp_rd) ? rd_data : 8'hzz;
   assign disp_char = tbr;

endmodule

// File: tb/tb_kbd_display_ports.sv
// Randomized bench for kbd_display_ports against a transaction-level model.
module tb_kbd_display_ports;

   logic       clock = 1'b0;
   logic       reset_;
   logic [7:0] key_code;
   logic       key_valid;
   logic [7:0] disp_char;
   logic       disp_valid;
   logic       disp_ack;
   wire  [7:0] d7_d0;
   logic [7:0] tb_drv;
   logic       tb_oe;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   logic       m_fi, m_ovr, m_fo, m_valid;
   logic [7:0] m_rbr, m_tbr;

   kbd_display_ports_if bus ();

   kbd_display_ports dut (
      .clock      (clock),
      .reset_     (reset_),
      .bus        (bus),
      .d7_d0      (d7_d0),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .disp_char  (disp_char),
      .disp_valid (disp_valid),
      .disp_ack   (disp_ack)
   );

   assign d7_d0 = tb_oe ? tb_drv : 8'hzz;
   for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup (d7_d0[i]);
   end

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] m_rsr();
      return {6'b0, m_ovr, m_fi};
   endfunction

   function automatic logic [7:0] m_tsr();
      return {7'b0, m_fo};
   endfunction

   task automatic model_reset();
      m_fi = 0; m_ovr = 0; m_rbr = 8'h00;
      m_fo = 1; m_tbr = 8'h00; m_valid = 0;
   endtask

   task automatic bus_idle();
      bus.s_kbd_ = 1'b1; bus.s_dsp_ = 1'b1; bus.a0 = 1'b0;
      bus.ior_ = 1'b1; bus.iow_ = 1'b1; tb_oe = 1'b0; tb_drv = 8'h00;
   endtask

   // All transaction tasks start and end 1 time unit after a rising edge.
   task automatic cpu_read(input logic kbd, input logic a, output logic [7:0] d);
      bus.s_kbd_ = !kbd; bus.s_dsp_ = kbd; bus.a0 = a; bus.ior_ = 1'b0;
      @(negedge clock);
      d = d7_d0;
      @(posedge clock); #1;
      bus_idle();
      @(posedge clock); #1;
   endtask

   task automatic cpu_write(input logic kbd, input logic a, input logic [7:0] v);
      bus.s_kbd_ = !kbd; bus.s_dsp_ = kbd; bus.a0 = a; bus.iow_ = 1'b0;
      tb_oe = 1'b1; tb_drv = v;
      @(posedge clock); #1;
      bus_idle();
      @(posedge clock); #1;
   endtask

   task automatic send_key(input logic [7:0] k);
      key_code = k; key_valid = 1'b1;
      @(posedge clock); #1;
      key_valid = 1'b0;
   endtask

   task automatic pulse_ack();
      disp_ack = 1'b1;
      @(posedge clock); #1;
      disp_ack = 1'b0;
   endtask

   // Transaction-level model updates
   task automatic m_key(input logic [7:0] k);
      if (m_fi) m_ovr = 1;
      m_fi = 1; m_rbr = k;
   endtask

   task automatic m_write_tbr(input logic [7:0] v);
      if (m_fo) begin m_tbr = v; m_fo = 0; m_valid = 1; end
   endtask

   task automatic m_ack();
      if (m_valid) begin m_valid = 0; m_fo = 1; end
   endtask

   task automatic chk_all_status(input string tag);
      logic [7:0] d;
      cpu_read(1, 0, d); chk({tag, "_rsr"}, d, m_rsr());
      cpu_read(0, 0, d); chk({tag, "_tsr"}, d, m_tsr());
      chk({tag, "_dvalid"}, {7'b0, disp_valid}, {7'b0, m_valid});
      chk({tag, "_dchar"}, disp_char, m_tbr);
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] v;
      bus_idle();
      key_code = 8'h00; key_valid = 1'b0; disp_ack = 1'b0;
      reset_ = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1 reset_ = 1'b1;
      @(posedge clock); #1;

      // reset state
      chk_all_status("rst");
      @(negedge clock);
      chk("rst_hiz", d7_d0, 8'hff);
      @(posedge clock); #1;

      // key receive
      send_key(8'h41); m_key(8'h41);
      cpu_read(1, 0, d); chk("key_rsr", d, 8'h01);
      cpu_read(1, 1, d); chk("key_rbr", d, 8'h41);
      m_fi = 0; m_ovr = 0;
      cpu_read(1, 0, d); chk("key_rsr_after_read", d, 8'h00);

      // overrun
      send_key(8'h31); m_key(8'h31);
      send_key(8'h32); m_key(8'h32);
      cpu_read(1, 0, d); chk("ovr_rsr", d, 8'h03);
      cpu_read(1, 1, d); chk("ovr_rbr", d, 8'h32);
      m_fi = 0; m_ovr = 0;
      cpu_read(1, 0, d); chk("ovr_rsr_after_read", d, 8'h00);

      // display write and ack
      cpu_write(0, 1, 8'h48); m_write_tbr(8'h48);
      chk("wr_dvalid", {7'b0, disp_valid}, 8'h01);
      chk("wr_dchar", disp_char, 8'h48);
      cpu_read(0, 0, d); chk("wr_tsr", d, 8'h00);
      cpu_write(0, 1, 8'h55); m_write_tbr(8'h55);
      cpu_read(0, 1, d); chk("busy_tbr", d, 8'h48);
      chk("busy_dchar", disp_char, 8'h48);
      cpu_write(1, 0, 8'hff);
      cpu_write(0, 0, 8'hff);
      cpu_write(1, 1, 8'h77);
      chk_all_status("wr_status_ignored");
      cpu_read(1, 1, d); chk("kbd_write_ignored_rbr", d, m_rbr);
      m_fi = 0; m_ovr = 0;
      pulse_ack(); m_ack();
      chk("ack_dvalid", {7'b0, disp_valid}, 8'h00);
      cpu_read(0, 0, d); chk("ack_tsr", d, 8'h01);
      pulse_ack(); m_ack();
      chk_all_status("stray_ack");

      // key on the same edge as end of an RBR read
      send_key(8'h10); m_key(8'h10);
      bus.s_kbd_ = 1'b0; bus.s_dsp_ = 1'b1; bus.a0 = 1'b1; bus.ior_ = 1'b0;
      @(posedge clock); #1;
      bus_idle();
      key_code = 8'h5a; key_valid = 1'b1;
      @(posedge clock); #1;
      key_valid = 1'b0;
      m_fi = 1; m_ovr = 0; m_rbr = 8'h5a;
      cpu_read(1, 0, d); chk("coll_rsr", d, 8'h01);
      cpu_read(1, 1, d); chk("coll_rbr", d, 8'h5a);
      m_fi = 0; m_ovr = 0;

      // both selects low, and selects low without a read strobe
      bus.s_kbd_ = 1'b0; bus.s_dsp_ = 1'b0; bus.a0 = 1'b0; bus.ior_ = 1'b0;
      @(negedge clock); chk("both_sel_hiz", d7_d0, 8'hff);
      bus.ior_ = 1'b1; bus.s_dsp_ = 1'b1; bus.a0 = 1'b1;
      @(posedge clock); #1;
      @(negedge clock); chk("no_ior_hiz", d7_d0, 8'hff);
      @(posedge clock); #1;
      bus_idle();
      @(posedge clock); #1;

      // reset mid-operation discards pending character
      send_key(8'h66); m_key(8'h66);
      cpu_write(0, 1, 8'h21); m_write_tbr(8'h21);
      @(posedge clock); #4;
      reset_ = 1'b0;
      model_reset();
      #1;
      chk("midrst_dvalid", {7'b0, disp_valid}, 8'h00);
      chk("midrst_dchar", disp_char, 8'h00);
      @(posedge clock); #1;
      reset_ = 1'b1;
      chk_all_status("midrst");

      // randomized traffic
      for (int it = 0; it < 300; it++) begin
         int op;
         op = int'($urandom_range(0, 7));
         v  = 8'($urandom);
         case (op)
            0: begin send_key(v); m_key(v); end
            1: begin
                  cpu_read(1, 1, d); chk("rnd_rbr", d, m_rbr);
                  m_fi = 0; m_ovr = 0;
               end
            2: begin cpu_read(1, 0, d); chk("rnd_rsr", d, m_rsr()); end
            3: begin cpu_write(0, 1, v); m_write_tbr(v); end
            4: begin pulse_ack(); m_ack(); end
            5: begin cpu_read(0, 0, d); chk("rnd_tsr", d, m_tsr()); end
            6: begin cpu_read(0, 1, d); chk("rnd_tbr", d, m_tbr); end
            default: begin
               case ($urandom_range(0, 2))
                  0: cpu_write(1, 0, v);
                  1: cpu_write(1, 1, v);
                  default: cpu_write(0, 0, v);
               endcase
            end
         endcase
         chk("rnd_dvalid", {7'b0, disp_valid}, {7'b0, m_valid});
         chk("rnd_dchar", disp_char, m_tbr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
